dcache_ctrl: RTL

- Direct-mapped, write-back, write-allocate data cache controller between the core's data port and cache_mem_glue_logic.
- Serves core loads/stores on a hit in zero added cycles.
- On a miss, stalls the core, writes back a dirty victim block if needed, fetches the missing block through the glue block's mem_req/mem_miss handshake, then replays the access as a hit.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_line_array.sv | 59 +++++
 rtl/dcache_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared geometry, FSM encodings and line layout for the direct-mapped data cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_pkg;

    localparam int BLOCKS   = 4;
    localparam int SETS     = 16;
    localparam int OFFSET_W = $clog2(BLOCKS) + 2;
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;

    typedef logic [2:0] state_t;
    localparam state_t LOOKUP    = 3'd0;
    localparam state_t WRITEBACK = 3'd1;
    localparam state_t WB_GAP    = 3'd2;
    localparam state_t ALLOCATE  = 3'd3;
    localparam state_t REFILL    = 3'd4;

    typedef logic [BLOCKS-1:0][31:0] block_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
        block_t           data;
    } line_t;

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port (full line or masked word).
// Latency: read 0 cycles, writes land at the clk edge.
// Backpressure: none; valid/dirty clear asynchronously on reset, tags and data keep contents.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  rd_idx,
    output line_t               rd_line,
    input  logic [INDEX_W-1:0]  wr_idx,
    input  logic                line_we,
    input  logic [TAG_W-1:0]    line_tag,
    input  block_t              line_dat,
    input  logic                word_we,
    input  logic [OFFSET_W-3:0] word_sel,
    input  logic [3:0]          word_mask,
    input  logic [31:0]         word_dat
);

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    block_t           data_q [SETS];

    always_comb begin
        rd_line       = '0;
        rd_line.valid = valid_q[rd_idx];
        rd_line.dirty = dirty_q[rd_idx];
        rd_line.tag   = tag_q[rd_idx];
        rd_line.data  = data_q[rd_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[wr_idx]  <= line_tag;
            data_q[wr_idx] <= line_dat;
        end else if (word_we) begin
            for (int b = 0; b < 4; b++) begin
                if (word_mask[b]) begin
                    data_q[wr_idx][word_sel][8*b +: 8] <= word_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller; DCACHE_STATS_EN adds hit/miss counters.
// Latency: hits 0 added cycles; misses stall through WRITEBACK/WB_GAP/ALLOCATE/REFILL then replay.
// Backpressure: cpu_stall holds the core; mem_miss from the glue extends WRITEBACK/ALLOCATE.
module dcache_ctrl #(
    parameter int BLOCKS = 4,
    parameter int SETS   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wd,
    input  logic [3:0]           cpu_mask,
    output logic [31:0]          cpu_rd,
    output logic                 cpu_stall,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    output logic                 mem_we,
    output logic [BLOCKS*32-1:0] mem_write_block,
    input  logic [BLOCKS*32-1:0] mem_read_block,
    input  logic                 mem_miss
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);
    import dcache_pkg::*;

    state_t              state;
    logic [OFFSET_W-3:0] req_word;
    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    line_t               rd_line;
    block_t              fill_blk;
    logic                hit;
    logic                mem_done;
    logic                store_hit;
    logic                unused_bits;

    assign req_word    = cpu_addr[OFFSET_W-1:2];
    assign req_idx     = cpu_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign req_tag     = cpu_addr[31:OFFSET_W+INDEX_W];
    assign unused_bits = ^cpu_addr[1:0];
    assign fill_blk    = mem_read_block;

    assign hit       = rd_line.valid && (rd_line.tag == req_tag);
    assign mem_done  = mem_req && !mem_miss;
    assign cpu_stall = cpu_req && ((state != LOOKUP) || !hit);
    assign cpu_rd    = rd_line.data[req_word];
    assign store_hit = (state == LOOKUP) && cpu_req && cpu_we && hit;

    dcache_line_array u_lines (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (req_idx),
        .rd_line   (rd_line),
        .wr_idx    (req_idx),
        .line_we   (state == REFILL),
        .line_tag  (req_tag),
        .line_dat  (fill_blk),
        .word_we   (store_hit),
        .word_sel  (req_word),
        .word_mask (cpu_mask),
        .word_dat  (cpu_wd)
    );

    // Transfer outputs are registered so they stay frozen while the glue counts beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= LOOKUP;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_write_block <= '0;
        end else begin
            case (state)
                LOOKUP: begin
                    if (cpu_req && !hit) begin
                        mem_req <= 1'b1;
                        if (rd_line.valid && rd_line.dirty) begin
                            state           <= WRITEBACK;
                            mem_we          <= 1'b1;
                            mem_addr        <= {rd_line.tag, req_idx, {OFFSET_W{1'b0}}};
                            mem_write_block <= rd_line.data;
                        end else begin
                            state    <= ALLOCATE;
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_done) begin
                        state   <= WB_GAP;
                        mem_req <= 1'b0;
                    end
                end
                // One idle cycle lets the glue beat counter fall back to zero.
                WB_GAP: begin
                    state    <= ALLOCATE;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                end
                ALLOCATE: begin
                    if (mem_done) begin
                        state   <= REFILL;
                        mem_req <= 1'b0;
                    end
                end
                REFILL: begin
                    state <= LOOKUP;
                end
                default: begin
                    state   <= LOOKUP;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic replay_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            replay_q   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            replay_q <= (state == REFILL);
            if ((state == LOOKUP) && cpu_req && hit && !replay_q) begin
                hit_count <= hit_count + 32'd1;
            end
            if ((state == LOOKUP) && cpu_req && !hit) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

    property p_hold_while_stalled;
        @(posedge clk) disable iff (!reset)
        cpu_stall |=> (cpu_req && $stable(cpu_we) && $stable(cpu_addr)
                       && $stable(cpu_wd) && $stable(cpu_mask));
    endproperty
    a_hold_while_stalled: assert property (p_hold_while_stalled);

    a_geometry_matches_pkg: assert property (@(posedge clk)
        (BLOCKS == dcache_pkg::BLOCKS) && (SETS == dcache_pkg::SETS));

endmodule
